// File: rtl/bus_pkg.sv
// Shared bus definitions used by both ends of the CPU request bus:
// responder state encoding, request kinds and byte-lane constants.
package bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } bus_state_e;

  typedef enum logic {
    K_READ  = 1'b0,
    K_WRITE = 1'b1
  } bus_kind_e;

  localparam logic [3:0] BUS_SEL_ALL = 4'b1111;

  // Expand a 4-bit lane select into a 32-bit data mask.
  function automatic logic [31:0] bus_lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/bus_sram_bank.sv
// Word-wide synchronous RAM with per-byte write enables and a registered,
// enable-gated read port whose output register clears on reset.
module bus_sram_bank #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_rd_en,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [31:0]          o_rd_data,
  input  logic [3:0]           i_wr_be,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [31:0]          i_wr_data
);

  logic [31:0] r_mem [2**ADDR_BITS];
  logic [31:0] r_rd_data;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_wr_be[b]) begin
        r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

  // The read register only moves when enabled, so it doubles as a hold register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bus_mem_responder.sv
// Far-end bus responder: accepts one read/write at a time, waits WAIT_CYCLES,
// then serves it from a byte-enabled word RAM with a busy/data handshake.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] cpu_dat_i,
  output logic        busy_o,
  output logic [31:0] cpu_dat_o,
  output bus_state_e  dbg_state_o
);

  localparam int TAG_LO = ADDR_BITS + 2;
  localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  bus_state_e        r_state;
  bus_state_e        w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:2]       r_adr;
  logic [3:0]        r_sel;
  logic [31:0]       r_dat;
  bus_kind_e         r_kind;
  logic [31:0]       r_out_mask;

  logic                 w_req;
  logic                 w_accept;
  logic                 w_hit_live;
  logic                 w_hit_lat;
  logic                 w_ld_hit;
  logic [3:0]           w_ld_sel;
  logic                 w_rd_en;
  logic [ADDR_BITS-1:0] w_rd_idx;
  logic [3:0]           w_wr_be;
  logic [31:0]          w_ram_q;
  logic                 w_unused;

  assign w_unused = &{1'b0, adr_i[1:0]};

  assign w_req      = read_i | write_i;
  assign w_accept   = (r_state == S_IDLE) && w_req;
  assign w_hit_live = (adr_i[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);
  assign w_hit_lat  = (r_adr[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);

  // With zero wait states the read is launched straight from the bus inputs.
  assign w_ld_hit = (r_state == S_IDLE) ? w_hit_live : w_hit_lat;
  assign w_ld_sel = (r_state == S_IDLE) ? sel_i : r_sel;
  assign w_rd_idx = (r_state == S_IDLE) ? adr_i[ADDR_BITS+1:2] : r_adr[ADDR_BITS+1:2];

  assign w_rd_en = (w_accept && !write_i && (WAIT_CYCLES == 0)) ||
                   ((r_state == S_WAIT) && (r_cnt == '0) && (r_kind == K_READ));

  assign w_wr_be = ((r_state == S_RESP) && (r_kind == K_WRITE) && w_hit_lat && !RST)
                   ? r_sel : 4'b0000;

  always_comb begin
    w_next = r_state;
    busy_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = w_req;
        if (w_req) begin
          w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (r_cnt == '0) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        busy_o = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_adr      <= '0;
      r_sel      <= '0;
      r_dat      <= '0;
      r_kind     <= K_READ;
      r_out_mask <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_adr  <= adr_i[31:2];
        r_sel  <= sel_i;
        r_dat  <= cpu_dat_i;
        r_kind <= write_i ? K_WRITE : K_READ;
        r_cnt  <= CNT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Mask is captured alongside the RAM read so the pair forms the read result.
      if (w_rd_en) begin
        r_out_mask <= w_ld_hit ? bus_lane_mask(w_ld_sel) : 32'h0;
      end
    end
  end

  bus_sram_bank #(
    .ADDR_BITS(ADDR_BITS)
  ) u_bank (
    .clk       (clk),
    .i_rst     (RST),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_idx),
    .o_rd_data (w_ram_q),
    .i_wr_be   (w_wr_be),
    .i_wr_addr (r_adr[ADDR_BITS+1:2]),
    .i_wr_data (r_dat)
  );

  assign cpu_dat_o   = w_ram_q & r_out_mask;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: two instances (2 and 0 wait states) driven by a
// bus-initiator task and checked against an array memory model.
module tb_bus_mem_responder;
  import bus_pkg::*;

  localparam int N_DUT = 2;
  int waits [N_DUT] = '{2, 0};

  logic             clk;
  logic             rst;
  logic [1:0]       rd;
  logic [1:0]       wr;
  logic [1:0][31:0] adr;
  logic [1:0][3:0]  sel;
  logic [1:0][31:0] din;
  logic [1:0]       busy;
  logic [1:0][31:0] dout;
  bus_state_e       st0;
  bus_state_e       st1;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mdl     [N_DUT][1024];
  logic [31:0] last_rd [N_DUT];
  logic [31:0] exp_q[$];

  bus_mem_responder #(.WAIT_CYCLES(2), .ADDR_BITS(10), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .RST(rst), .read_i(rd[0]), .write_i(wr[0]), .adr_i(adr[0]),
    .sel_i(sel[0]), .cpu_dat_i(din[0]), .busy_o(busy[0]), .cpu_dat_o(dout[0]),
    .dbg_state_o(st0)
  );

  bus_mem_responder #(.WAIT_CYCLES(0), .ADDR_BITS(10), .BASE_ADDR(32'h0)) u_dut1 (
    .clk(clk), .RST(rst), .read_i(rd[1]), .write_i(wr[1]), .adr_i(adr[1]),
    .sel_i(sel[1]), .cpu_dat_i(din[1]), .busy_o(busy[1]), .cpu_dat_o(dout[1]),
    .dbg_state_o(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: flat word array, decode by plain address arithmetic
  function automatic logic model_hit(input logic [31:0] a);
    return (a >> 12) == 32'h0;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    if (s[0]) m = m | 32'h0000_00FF;
    if (s[1]) m = m | 32'h0000_FF00;
    if (s[2]) m = m | 32'h00FF_0000;
    if (s[3]) m = m | 32'hFF00_0000;
    return m;
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] v);
    int idx;
    idx = int'((a % 32'h1000) / 4);
    if (model_hit(a)) mdl[d][idx] = (mdl[d][idx] & ~lane_bits(s)) | (v & lane_bits(s));
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a,
                                             input logic [3:0] s);
    int idx;
    idx = int'((a % 32'h1000) / 4);
    if (!model_hit(a)) return 32'h0;
    return mdl[d][idx] & lane_bits(s);
  endfunction

  // driver: one full initiator transaction, held until busy drops
  task automatic txn(input int d, input logic do_rd, input logic do_wr,
                     input logic [31:0] a, input logic [3:0] s, input logic [31:0] v,
                     output logic [31:0] got);
    int          n_busy;
    logic [31:0] last;
    logic [31:0] exp;
    @(posedge clk); #1;
    rd[d] = do_rd; wr[d] = do_wr; adr[d] = a; sel[d] = s; din[d] = v;
    n_busy = 0;
    last   = 32'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy[d]) begin
        n_busy++;
        last = dout[d];
        if (k == 1) begin
          adr[d] = $urandom; sel[d] = 4'($urandom); din[d] = $urandom;
        end
      end else begin
        break;
      end
    end
    chk($sformatf("busy_len d%0d", d), 32'(n_busy), 32'(2 + waits[d]));
    if (do_wr) begin
      model_write(d, a, s, v);
      chk($sformatf("hold_after_wr d%0d", d), dout[d], last_rd[d]);
    end else begin
      exp_q.push_back(model_read(d, a, s));
      exp = exp_q.pop_front();
      chk($sformatf("rdata d%0d a=%h s=%h", d, a, s), last, exp);
      last_rd[d] = exp;
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    adr[d] = $urandom; sel[d] = 4'($urandom); din[d] = $urandom;
    got = last;
  endtask

  initial begin
    logic [31:0] g;
    logic [31:0] a;
    int          d;
    int          kind;

    rst = 1'b1; rd = '0; wr = '0; adr = '0; sel = '0; din = '0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;

    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("rst_busy0", 32'(busy[0]), 32'h0);
      chk("rst_dout0", dout[0], 32'h0);
      chk("rst_busy1", 32'(busy[1]), 32'h0);
      chk("rst_dout1", dout[1], 32'h0);
    end
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy0", 32'(busy[0] | busy[1]), 32'h0);
      chk("idle_dout", dout[0] | dout[1], 32'h0);
      chk("idle_state0", 32'(st0), 32'(S_IDLE));
    end

    // preload the words used later so every model read is defined
    for (int dd = 0; dd < N_DUT; dd++) begin
      for (int w = 0; w < 16; w++) begin
        txn(dd, 1'b0, 1'b1, 32'(w * 4), BUS_SEL_ALL, $urandom, g);
      end
    end

    txn(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, g);
    txn(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, g);
    chk("rd_deadbeef", g, 32'hDEADBEEF);
    txn(0, 1'b0, 1'b1, 32'h10, 4'b0101, 32'h11223344, g);
    txn(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, g);
    chk("lanes_0101", g, 32'hDE22BE44);
    txn(0, 1'b1, 1'b0, 32'h10, 4'b0011, 32'h0, g);
    chk("rd_sel_0011", g, 32'h0000BE44);
    txn(0, 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0, g);
    chk("rd_sel_0000", g, 32'h0);
    txn(0, 1'b0, 1'b1, 32'h10, 4'b0000, 32'hCAFEF00D, g);
    txn(0, 1'b1, 1'b0, 32'h13, 4'hF, 32'h0, g);
    chk("wr_sel_0000_kept", g, 32'hDE22BE44);
    txn(0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, g);
    chk("oor_read", g, 32'h0);
    txn(0, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, g);
    txn(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, g);
    txn(0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, g);
    chk("oor_read_after_wr", g, 32'h0);

    txn(1, 1'b1, 1'b1, 32'h4, 4'hF, 32'hA5A5A5A5, g);
    txn(1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0, g);
    chk("w0_both_is_write", g, 32'hA5A5A5A5);

    // reset pulsed while the write sits in WAIT
    @(posedge clk); #1;
    wr[0] = 1'b1; adr[0] = 32'h8; sel[0] = 4'hF; din[0] = 32'h12345678;
    @(negedge clk);
    chk("midrst_busy_acc", 32'(busy[0]), 32'h1);
    @(negedge clk);
    chk("midrst_in_wait", 32'(st0), 32'(S_WAIT));
    rst = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy[0]), 32'h0);
    chk("midrst_state", 32'(st0), 32'(S_IDLE));
    chk("midrst_dout", dout[0], 32'h0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    txn(0, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0, g);

    // randomized traffic on both instances
    for (int n = 0; n < 240; n++) begin
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      a    = {22'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 4) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
      txn(d, kind != 1, kind != 0, a, 4'($urandom), $urandom, g);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
